// File: rtl/logic_func_pkg.sv
// Shared definitions for the logic_func_pipe slice: truth-table op codes
// and a 2-input NOR helper for the cross-check datapath (NOR_XCHK_EN).
package logic_func_pkg;

  // Truth-table code: bit index {x, y} selects the result bit.
  typedef logic [3:0] op_t;

  localparam op_t OP_ZERO    = 4'b0000;
  localparam op_t OP_NOR     = 4'b0001;
  localparam op_t OP_INHIBIT = 4'b0100;
  localparam op_t OP_XOR     = 4'b0110;
  localparam op_t OP_NAND    = 4'b0111;
  localparam op_t OP_AND     = 4'b1000;
  localparam op_t OP_OR      = 4'b1110;
  localparam op_t OP_ONE     = 4'b1111;

  // The only gate the cross-check datapath is allowed to use.
  function automatic logic nor2(input logic a, input logic b);
    return ~(a | b);
  endfunction

endpackage

// File: rtl/logic_func_bit.sv
// One-bit truth-table select r = op[{x, y}].
// With NOR_XCHK_EN defined, a NOR-only implementation of the same select
// (logic_func_bit_nor) is also compiled for the result cross-check.
module logic_func_bit
  import logic_func_pkg::*;
(
  input  logic x,
  input  logic y,
  input  op_t  op,
  output logic r
);

  assign r = op[{x, y}];

endmodule

`ifdef NOR_XCHK_EN
module logic_func_bit_nor
  import logic_func_pkg::*;
(
  input  logic x,
  input  logic y,
  input  op_t  op,
  output logic r
);

  logic nx, ny;
  logic [3:0] nop;
  logic [3:0] mt;     // minterms: mt[k] = 1 when {x, y} == k
  logic [3:0] nmt;
  logic [3:0] t;      // minterm gated by its op bit
  logic n01, n23, or01, or23, nr;

  // Inverters are NORs with both inputs tied together.
  assign nx = nor2(x, x);
  assign ny = nor2(y, y);
  for (genvar k = 0; k < 4; k++) begin : gen_nop
    assign nop[k] = nor2(op[k], op[k]);
  end

  // a & b == nor(~a, ~b)
  assign mt[0] = nor2(x,  y);
  assign mt[1] = nor2(x,  ny);
  assign mt[2] = nor2(nx, y);
  assign mt[3] = nor2(nx, ny);

  for (genvar k = 0; k < 4; k++) begin : gen_term
    assign nmt[k] = nor2(mt[k], mt[k]);
    assign t[k]   = nor2(nmt[k], nop[k]);
  end

  // Four-input OR folded into a tree of NOR + NOR-inverter pairs.
  assign n01  = nor2(t[0], t[1]);
  assign n23  = nor2(t[2], t[3]);
  assign or01 = nor2(n01, n01);
  assign or23 = nor2(n23, n23);
  assign nr   = nor2(or01, or23);
  assign r    = nor2(nr, nr);

endmodule
`endif

// File: rtl/logic_func_pipe.sv
// Registered WIDTH-bit two-operand logic unit: any of the 16 Boolean
// functions chosen per beat by a truth-table op code, valid/ready input,
// 2-entry output buffer, wrapping handshake counter.
// Optional macro NOR_XCHK_EN: recompute each result with a NOR-only
// datapath and raise the sticky err flag on any disagreement.
module logic_func_pipe
  import logic_func_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic [CNT_W-1:0] count,
  output logic             err
);

  logic [WIDTH-1:0] res;    // primary result of the beat on x/y/op
  logic [WIDTH-1:0] head;   // oldest buffered result, drives r
  logic [WIDTH-1:0] tail;   // second entry, valid only when occ == 2
  logic [1:0]       occ;
  logic             push;
  logic             pop;

  // Primary datapath: one truth-table select per bit.
  for (genvar i = 0; i < WIDTH; i++) begin : gen_bit
    logic_func_bit u_bit (
      .x  (x[i]),
      .y  (y[i]),
      .op (op),
      .r  (res[i])
    );
  end

  // Handshakes depend only on registered occupancy, never on out_ready.
  assign in_ready  = (occ != 2'd2);
  assign out_valid = (occ != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign r         = head;

  // Occupancy and completed-handshake counter.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ   <= 2'd0;
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
      if (pop) count <= count + CNT_W'(1);
    end
  end

  // Head entry: loads a new beat when it would otherwise be empty, or
  // promotes the tail when the head is popped from a full buffer.
  // NOTE: only the head is reset, so r reads 0 after reset; the tail is
  // never observed before it is written and needs no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
    end else if (push && (occ == 2'd0 || (occ == 2'd1 && pop))) begin
      head <= res;
    end else if (pop && occ == 2'd2) begin
      head <= tail;
    end
  end

  // Tail entry: second beat queued behind a head that is not leaving.
  always_ff @(posedge clk) begin
    if (!rst && push && occ == 2'd1 && !pop) tail <= res;
  end

`ifdef NOR_XCHK_EN
  logic [WIDTH-1:0] res_nor;
  logic             err_q;

  // Independent NOR-only datapath for the cross-check.
  for (genvar i = 0; i < WIDTH; i++) begin : gen_bit_nor
    logic_func_bit_nor u_bit_nor (
      .x  (x[i]),
      .y  (y[i]),
      .op (op),
      .r  (res_nor[i])
    );
  end

  // Sticky mismatch flag, set when a disagreeing result is pushed.
  always_ff @(posedge clk) begin
    if (rst)                          err_q <= 1'b0;
    else if (push && res != res_nor)  err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_logic_func_pipe.sv
// Self-checking bench for logic_func_pipe: op-code table, back-pressure,
// streaming push/pop, counter wrap (CNT_W = 4 instance), mid-stream reset,
// random beats, and (with NOR_XCHK_EN) a forced primary-path fault.
module tb_logic_func_pipe;
  import logic_func_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready, in_ready_w;
  logic [7:0] x, y;
  logic [3:0] op;
  logic       out_valid, out_valid_w;
  logic       out_ready;
  logic [7:0] r, r_w;
  logic [15:0] count;
  logic [3:0]  count_w;
  logic       err, err_w;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  logic_func_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .r(r), .count(count), .err(err)
  );

  // Same stimulus, narrow counter for the wrap check.
  logic_func_pipe #(.WIDTH(8), .CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
    .x(x), .y(y), .op(op), .out_valid(out_valid_w), .out_ready(out_ready),
    .r(r_w), .count(count_w), .err(err_w)
  );

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic [3:0] op;
    logic [7:0] r;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] bx, input logic [7:0] by, input logic [3:0] bop);
    in_valid = 1'b1;
    x = bx;
    y = by;
    op = bop;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // Sum-of-minterms reference for random beats.
  function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] o);
    return ({8{o[3]}} &  a &  b) | ({8{o[2]}} &  a & ~b) |
           ({8{o[1]}} & ~a &  b) | ({8{o[0]}} & ~a & ~b);
  endfunction

  initial begin
    logic [7:0] exp_r;
    logic [7:0] rx, ry;
    logic [3:0] rop;

    vecs[0]  = '{8'hF0, 8'hCC, OP_INHIBIT, 8'h30};
    vecs[1]  = '{8'hF0, 8'hCC, OP_NOR,     8'h03};
    vecs[2]  = '{8'hF0, 8'hCC, OP_XOR,     8'h3C};
    vecs[3]  = '{8'hF0, 8'hCC, OP_AND,     8'hC0};
    vecs[4]  = '{8'hF0, 8'hCC, OP_OR,      8'hFC};
    vecs[5]  = '{8'hF0, 8'hCC, OP_NAND,    8'h3F};
    vecs[6]  = '{8'hF0, 8'hCC, OP_ZERO,    8'h00};
    vecs[7]  = '{8'hF0, 8'hCC, OP_ONE,     8'hFF};
    vecs[8]  = '{8'hF0, 8'hCC, 4'b1010,    8'hCC};
    vecs[9]  = '{8'hF0, 8'hCC, 4'b1100,    8'hF0};
    vecs[10] = '{8'hF0, 8'hCC, 4'b0010,    8'h0C};
    vecs[11] = '{8'hF0, 8'hCC, 4'b1001,    8'hC3};
    vecs[12] = '{8'hA5, 8'h0F, OP_AND,     8'h05};
    vecs[13] = '{8'hA5, 8'h0F, OP_INHIBIT, 8'hA0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    x = '0; y = '0; op = '0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_r",         32'(r),         32'd0);
    check("rst_count",     32'(count),     32'd0);
    check("rst_err",       32'(err),       32'd0);

    // Op-code table: one beat, check one cycle later, then drain.
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      beat(vecs[i].x, vecs[i].y, vecs[i].op);
      check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
      step();
      check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d_r", i), 32'(r), 32'(vecs[i].r));
      in_valid = 1'b0;
      step();
    end
    check("table_count", 32'(count), 32'd14);
    check("table_drained", 32'(out_valid), 32'd0);

    // Back-pressure: three beats offered, two accepted, third held.
    do_reset();
    out_ready = 1'b0;
    beat(8'h01, 8'h00, OP_XOR);
    step();
    check("bp1_r", 32'(r), 32'h01);
    check("bp1_in_ready", 32'(in_ready), 32'd1);
    beat(8'h02, 8'h00, OP_XOR);
    step();
    check("bp2_in_ready", 32'(in_ready), 32'd0);
    check("bp2_r", 32'(r), 32'h01);
    beat(8'h03, 8'h00, OP_XOR);
    step();
    check("bp3_in_ready", 32'(in_ready), 32'd0);
    check("bp3_r_held", 32'(r), 32'h01);
    out_ready = 1'b1;
    step();
    check("bp_pop1_r", 32'(r), 32'h02);
    check("bp_pop1_in_ready", 32'(in_ready), 32'd1);
    step();
    check("bp_pop2_r", 32'(r), 32'h03);
    in_valid = 1'b0;
    step();
    check("bp_empty", 32'(out_valid), 32'd0);
    check("bp_count", 32'(count), 32'd3);

    // Streaming at occupancy 1: ten consecutive beats, out_ready held high.
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      rx = 8'(k * 17 + 3);
      beat(rx, 8'h5A, OP_XOR);
      step();
      check($sformatf("stream%0d_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("stream%0d_r", k), 32'(r), 32'(rx ^ 8'h5A));
    end
    in_valid = 1'b0;
    step();
    check("stream_count", 32'(count), 32'd10);
    check("stream_empty", 32'(out_valid), 32'd0);

    // Seven more handshakes: 17 total since reset, 4-bit counter wraps to 1.
    for (int k = 0; k < 7; k++) begin
      beat(8'(k), 8'hFF, OP_AND);
      step();
      in_valid = 1'b0;
      step();
    end
    check("wrap_count_w", 32'(count_w), 32'd1);
    check("wrap_count", 32'(count), 32'd17);

    // Reset with the buffer full and a beat presented in the reset cycle.
    out_ready = 1'b0;
    beat(8'h11, 8'h00, OP_OR);
    step();
    beat(8'h22, 8'h00, OP_OR);
    step();
    check("mid_full_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    beat(8'h33, 8'h00, OP_OR);
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    check("mid_out_valid", 32'(out_valid), 32'd0);
    check("mid_count", 32'(count), 32'd0);
    check("mid_err", 32'(err), 32'd0);
    check("mid_in_ready", 32'(in_ready), 32'd1);
    step();
    check("mid_dropped", 32'(out_valid), 32'd0);

    // Random beats against the minterm model.
    out_ready = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      rx  = 8'($urandom);
      ry  = 8'($urandom);
      rop = 4'($urandom_range(0, 15));
      exp_r = model(rx, ry, rop);
      beat(rx, ry, rop);
      step();
      if (r !== exp_r) check($sformatf("rand%0d_r", k), 32'(r), 32'(exp_r));
      else n_cmp++;
      in_valid = 1'b0;
      step();
    end
    check("rand_err", 32'(err), 32'd0);
    check("rand_count", 32'(count), 32'd1000);

`ifdef NOR_XCHK_EN
    // Corrupt one primary result bit for one beat; err must stick until rst.
    beat(8'hF0, 8'hCC, OP_AND);
    force dut.res = 8'hC1;
    step();
    release dut.res;
    in_valid = 1'b0;
    check("xchk_err_set", 32'(err), 32'd1);
    beat(8'h0F, 8'h33, OP_OR);
    step();
    in_valid = 1'b0;
    step();
    check("xchk_err_sticky", 32'(err), 32'd1);
    do_reset();
    check("xchk_err_cleared", 32'(err), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
